bitcnt_pipe: RTL and testbench
==============================

# bitcnt_pipe

Pipelined, elastic bit-counting unit for the integer execute path. It implements the RISC-V Zbb counting operations: `cpop`, `clz` and `ctz`, plus their 32-bit word forms on 64-bit builds. All modes reduce to one shared adder-tree popcount, split into a configurable number of register stages. A valid/ready handshake, a tag passthrough and a flush input let it sit behind the issue queue like any other multi-cycle FU.

## Interface
Parameters:
- `XLEN`, default 32: operand width; must be a power of two, ≥ 8.
- `STAGES`, default 2: number of register stages, 1..`$clog2(XLEN)`; equals latency.
- `TAG_W`, default 6: width of the opaque tag carried alongside each operation.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `flush`  in  1: kill all in-flight operations.
- `in_valid`  in  1: an operation is offered.
- `in_ready`  out  1: the unit accepts the operation this cycle.
- `in_op`  in  2: operation select; 0 = CPOP, 1 = CLZ, 2 = CTZ, 3 = reserved (treated as CPOP).
- `in_word`  in  1: word mode; operate on bits [31:0] only. Ignored (forced 0) when `XLEN` = 32.
- `in_data`  in  `XLEN`: operand.
- `in_tag`  in  `TAG_W`: tag.
- `out_valid`  out  1: a result is available.
- `out_ready`  in  1: the consumer takes the result.
- `out_result`  out  `$clog2(XLEN)+1`: count, zero-extended by the consumer.
- `out_tag`  out  `TAG_W`: tag of the result.

## Operation
Preprocessing in stage 1 is combinational. Let W = 32 in word mode, otherwise `XLEN`, and let x = the low W bits of `in_data`, zero-padded to `XLEN`.
- CPOP: popcount(x).
- CTZ: popcount(~x & (x − 1)), computed over W bits. Result is W when x = 0.
- CLZ: bit-reverse the low W bits of x, then apply the CTZ rule. Result is W when x = 0.

Popcount uses a binary adder tree with LEVELS = `$clog2(XLEN)` levels. Level i produces `XLEN`>>i sums, each i+1 bits wide. The final sum is `$clog2(XLEN)+1` bits and cannot overflow.

Stage placement:
- Stage s (1..`STAGES`) holds tree levels ((s−1)·LEVELS/`STAGES`, s·LEVELS/`STAGES`], using integer division.
- Each stage ends in a register bank holding valid, partial sums and tag.
- The last bank drives `out_*` directly, so the output is always registered.

Elastic pipeline:
- Stage s advances when it is empty, or when its downstream stage advances. For the last stage, "downstream advances" means `out_ready`.
- `in_ready` = stage 1 empty, or stage 1 advancing. It is combinational from `out_ready` through the chain; no skid buffer.
- Acceptance happens when `in_valid` && `in_ready`.
- When a stage holds and does not advance, its data and tag registers keep their value.

Flush:
- `flush` clears every stage valid at the next edge and blocks acceptance in the same cycle.
- `in_ready` may be high during flush, but the operation is dropped.
- `out_valid` goes low the cycle after `flush`.
- The result on a cycle with `flush` and `out_valid` && `out_ready` both high still counts as consumed.

Reserved op 3 behaves exactly as CPOP.

## Timing
- Reset values: `out_valid` = 0, `out_result` = 0, `out_tag` = 0, all internal valids = 0. `in_ready` = 1 immediately after reset.
- Reset asserted mid-operation discards all in-flight work; no result is produced for it.
- Latency: an operation accepted at edge n appears with `out_valid` = 1 after edge n+`STAGES−1`. It is visible on the cycle following edge n+`STAGES−1`, i.e. `STAGES` cycles after acceptance.
- Throughput: one operation per cycle while `out_ready` = 1.
- Backpressure with `out_ready` = 0 and full pipeline: `in_ready` = 0. `out_result`/`out_tag` stay stable until consumed.
- Simultaneous consume and accept with the pipeline full: allowed; the pipeline shifts by one.
- Operations leave in acceptance order; tags are never reordered.

## Test plan
- Reset, `XLEN`=32, `STAGES`=2: CPOP of `0xF0F0_0001` -> `out_result` = 9 two cycles after accept, tag echoed; `out_*` = 0 during reset.
- Zero operands, `XLEN`=64: CLZ 0 -> 64; CTZ 0 -> 64; CLZ/CTZ 0 with `in_word`=1 -> 32; CPOP of all-ones with `in_word`=1 -> 32.
- Edge values, `XLEN`=64: CLZ `0x0000_0000_8000_0000` -> 32; the same with `in_word`=1 -> 0; CTZ `0x8000_0000_0000_0000` -> 63; CLZ `0x1` -> 63.
- Backpressure: stream 8 ops with `out_ready` toggling 1,0,0,1,… -> all 8 results emerge in order with correct tags, none lost or duplicated; `in_ready` = 0 whenever all `STAGES` are full and `out_ready` = 0.
- Flush: pipeline full, assert `flush` with `in_valid`=1 -> `out_valid` = 0 next cycle; the offered op is dropped; the next accepted op returns correctly after `STAGES` cycles.
- Sweep `STAGES` 1..LEVELS for `XLEN`=32 and 64 with 10k random ops against a reference model -> results match, latency equals `STAGES` exactly.

Source files
------------

// File: rtl/bitcnt_pipe.sv
// Pipelined, elastic Zbb bit counter: cpop, clz and ctz (plus 32-bit word forms when XLEN > 32).
// Every mode reduces to one popcount adder tree whose levels are spread over STAGES register banks.
module bitcnt_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic                  in_word,
  input  logic [XLEN-1:0]       in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(XLEN):0] out_result,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int LEVELS = $clog2(XLEN);
  localparam int RW     = LEVELS + 1;

  localparam logic [1:0]      OP_CLZ = 2'd1;
  localparam logic [1:0]      OP_CTZ = 2'd2;
  localparam logic [XLEN-1:0] ONE    = {{(XLEN-1){1'b0}}, 1'b1};

  // Last tree level registered by bank k.
  function automatic int bnd(input int k);
    return (k * LEVELS) / STAGES;
  endfunction

  // Bank whose registered level feeds tree level lvl+1 (0 if none).
  function automatic int src_stage(input int lvl);
    int r;
    r = 0;
    for (int k = 1; k < STAGES; k++) begin
      if (bnd(k) == lvl) r = k;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage-1 preprocessing: turn clz/ctz into a popcount of the trailing-zero mask
  // ---------------------------------------------------------------------------
  logic                   word;
  logic [XLEN-1:0]        wmask;
  logic [XLEN-1:0]        x;
  logic [XLEN-1:0]        rev_full;
  logic [XLEN-1:0]        rev;
  logic [XLEN-1:0]        y;
  logic [XLEN-1:0]        tz;
  logic [XLEN-1:0]        cnt_bits;
  logic [XLEN-1:0][RW-1:0] pre;

  if (XLEN > 32) begin : g_word
    logic [XLEN-1:0] rev_w;

    assign word  = in_word;
    assign wmask = word ? {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF} : '1;

    always_comb begin
      rev_w = '0;
      for (int j = 0; j < 32; j++) rev_w[j] = x[31-j];
    end

    assign rev = word ? rev_w : rev_full;
  end else begin : g_noword
    logic unused_word;

    assign unused_word = in_word;
    assign word        = 1'b0;
    assign wmask       = '1;
    assign rev         = rev_full;
  end

  assign x = in_data & wmask;

  always_comb begin
    rev_full = '0;
    for (int j = 0; j < XLEN; j++) rev_full[j] = x[XLEN-1-j];
  end

  // Masking with wmask keeps a zero word-mode operand at 32 instead of XLEN.
  always_comb begin
    y        = (in_op == OP_CLZ) ? rev : x;
    tz       = ~y & (y - ONE) & wmask;
    cnt_bits = (in_op == OP_CLZ || in_op == OP_CTZ) ? tz : x;
  end

  always_comb begin
    pre = '0;
    for (int j = 0; j < XLEN; j++) pre[j] = {{(RW-1){1'b0}}, cnt_bits[j]};
  end

  // ---------------------------------------------------------------------------
  // Adder tree: level l sums pairs of level l-1, sourced from a bank at boundaries
  // ---------------------------------------------------------------------------
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NI  = XLEN >> (l - 1);
    localparam int NO  = XLEN >> l;
    localparam int SRC = src_stage(l - 1);

    logic [NI-1:0][RW-1:0] src;
    logic [NO-1:0][RW-1:0] sum;

    if (l == 1) begin : g_pre
      assign src = pre;
    end else if (SRC != 0) begin : g_bank
      assign src = g_stg[SRC].dat;
    end else begin : g_comb
      assign src = g_lvl[l-1].sum;
    end

    always_comb begin
      sum = '0;
      for (int j = 0; j < NO; j++) sum[j] = src[2*j] + src[2*j+1];
    end
  end

  // ---------------------------------------------------------------------------
  // Register banks with elastic valid/ready chaining
  // ---------------------------------------------------------------------------
  for (genvar k = 1; k <= STAGES; k++) begin : g_stg
    localparam int B = bnd(k);
    localparam int N = XLEN >> B;

    logic                  v;
    logic                  adv;
    logic                  down;
    logic                  nv;
    logic [TAG_W-1:0]      ntag;
    logic [TAG_W-1:0]      tag;
    logic [N-1:0][RW-1:0]  dat;

    if (k == STAGES) begin : g_last
      assign down = out_ready;
    end else begin : g_mid
      assign down = g_stg[k+1].adv;
    end

    if (k == 1) begin : g_head
      assign nv   = in_valid;
      assign ntag = in_tag;
    end else begin : g_body
      assign nv   = g_stg[k-1].v;
      assign ntag = g_stg[k-1].tag;
    end

    assign adv = !v || down;

    // Data only moves with a valid token, so a stalled or idle bank holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v   <= 1'b0;
        tag <= '0;
        dat <= '0;
      end else begin
        if (flush) begin
          v <= 1'b0;
        end else if (adv) begin
          v <= nv;
        end
        if (adv && nv) begin
          tag <= ntag;
          dat <= g_lvl[B].sum;
        end
      end
    end
  end

  assign in_ready   = g_stg[1].adv;
  assign out_valid  = g_stg[STAGES].v;
  assign out_tag    = g_stg[STAGES].tag;
  assign out_result = g_stg[STAGES].dat[0];

endmodule

// File: tb/tb_bitcnt_pipe.sv
// Bench for bitcnt_pipe (XLEN=64, STAGES=3): directed edge cases, backpressure, flush and reset,
// then random traffic scored against a bit-scanning reference model and a cycle-level occupancy model.
module tb_bitcnt_pipe;

  localparam int XLEN   = 64;
  localparam int STAGES = 3;
  localparam int TAG_W  = 6;
  localparam int RW     = $clog2(XLEN) + 1;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic              in_word;
  logic [XLEN-1:0]   in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     out_result;
  logic [TAG_W-1:0]  out_tag;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int cyc   = 0;

  typedef struct {
    int               res;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t q[$];

  bitcnt_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_data    (in_data),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Reference: scan bits directly rather than using the ~x & (x-1) trick.
  function automatic int ref_count(input logic [1:0] op, input logic w, input logic [XLEN-1:0] d);
    int wd;
    int n;
    int i;
    wd = (w && XLEN > 32) ? 32 : XLEN;
    n  = 0;
    if (op == 2'd1) begin
      i = wd - 1;
      while (i >= 0 && !d[i]) begin n++; i--; end
    end else if (op == 2'd2) begin
      i = 0;
      while (i < wd && !d[i]) begin n++; i++; end
    end else begin
      for (int b = 0; b < wd; b++) n += int'(d[b]);
    end
    return n;
  endfunction

  function automatic logic [XLEN-1:0] rnd64();
    logic [XLEN-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: v = v >> $urandom_range(0, 63);
      1: v = v << $urandom_range(0, 63);
      2: v = 64'h1 << $urandom_range(0, 63);
      3: v = '0;
      4: v = '1;
      default: ;
    endcase
    return v;
  endfunction

  // Occupancy model: a token is at the output exactly STAGES cycles after acceptance unless
  // something ahead of it is still waiting, and in_ready drops only when all STAGES slots hold tokens.
  always @(negedge clk) begin
    bit exp_ov;
    if (!rst_n) begin
      q.delete();
    end else begin
      check("in_ready", 64'((q.size() < STAGES) || out_ready), 64'(in_ready));
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= STAGES);
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov && out_valid) begin
        check("result", 64'(out_result), 64'(q[0].res));
        check("tag", 64'(out_tag), 64'(q[0].tag));
        if (out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back('{ref_count(in_op, in_word, in_data), in_tag, cyc});
    end
  end

  task automatic send(input logic [1:0] op, input logic w, input logic [XLEN-1:0] d,
                      input logic [TAG_W-1:0] t);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_word  = w;
    in_data  = d;
    in_tag   = t;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run1(input string name, input logic [1:0] op, input logic w,
                      input logic [XLEN-1:0] d, input logic [TAG_W-1:0] t, input int exp);
    int lat;
    lat       = 0;
    out_ready = 1'b1;
    send(op, w, d, t);
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    check({name, "_lat"}, 64'(lat), 64'(STAGES));
    check({name, "_res"}, 64'(out_result), 64'(exp));
    check({name, "_tag"}, 64'(out_tag), 64'(t));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() > 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_word   = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    run1("cpop_f0f0", 2'd0, 1'b0, 64'hF0F0_0001, 6'd1, 9);
    run1("clz_zero", 2'd1, 1'b0, 64'h0, 6'd2, 64);
    run1("ctz_zero", 2'd2, 1'b0, 64'h0, 6'd3, 64);
    run1("clzw_zero", 2'd1, 1'b1, 64'h0, 6'd4, 32);
    run1("ctzw_zero", 2'd2, 1'b1, 64'h0, 6'd5, 32);
    run1("cpopw_ones", 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd6, 32);
    run1("clz_bit31", 2'd1, 1'b0, 64'h0000_0000_8000_0000, 6'd7, 32);
    run1("clzw_bit31", 2'd1, 1'b1, 64'h0000_0000_8000_0000, 6'd8, 0);
    run1("ctz_bit63", 2'd2, 1'b0, 64'h8000_0000_0000_0000, 6'd9, 63);
    run1("clz_one", 2'd1, 1'b0, 64'h1, 6'd10, 63);
    run1("op3_ones", 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd11, 64);
    run1("cpopw_hi", 2'd0, 1'b1, 64'hFFFF_FFFF_0000_0003, 6'd12, 2);
    run1("ctzw_hi", 2'd2, 1'b1, 64'hFFFF_FFFF_0000_0000, 6'd13, 32);

    // Reset in the middle of two in-flight ops: nothing may come out afterwards.
    send(2'd0, 1'b0, 64'hFF, 6'd20);
    send(2'd0, 1'b0, 64'hF, 6'd21);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < STAGES + 2; i++) begin
      @(negedge clk);
      check("midrst_no_result", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Backpressure: out_ready follows 1,0,0,1,... while eight ops stream in.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd64(), 6'(40 + i));
      end
      begin
        for (int i = 0; i < 48; i++) begin
          out_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 64'(n_out - n0), 64'd8);

    // Flush with a full pipeline and an op on offer while in_ready is high.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) send(2'd0, 1'b0, rnd64(), 6'(50 + i));
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_op     = 2'd0;
    in_word   = 1'b0;
    in_data   = 64'h7;
    in_tag    = 6'd60;
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < STAGES + 1; i++) begin
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    run1("post_flush", 2'd2, 1'b0, 64'h100, 6'd61, 8);

    // Random stream at full throughput: latency must stay exactly STAGES.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_word   = 1'($urandom_range(0, 1));
      in_data   = rnd64();
      in_tag    = 6'($urandom);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end

    // Random stream with backpressure and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_word   = 1'($urandom_range(0, 1));
      in_data   = rnd64();
      in_tag    = 6'($urandom);
      out_ready = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
